// File: rtl/mux2_sel_pkg.sv
// mux2_sel_pkg
//   Shared constants for the datapath selection primitives. Holds the
//   default data width so every mux instance in a selection tree picks up
//   the same word size without repeating the number at each instance.
//
//   Contents:
//     MUX2_DEFAULT_WIDTH - default word width (32) for datapath muxes
package mux2_sel_pkg;

    localparam int unsigned MUX2_DEFAULT_WIDTH = 32;

endpackage : mux2_sel_pkg

// File: rtl/mux2_sel.sv
// mux2_sel
//   Parameterised 2:1 word multiplexer, the leaf primitive of the processor
//   datapath selection trees (a 4:1 selector is three of these). Provides a
//   zero-latency combinational result plus a registered copy of it for
//   pipelined or multicycle paths.
//
//   Parameters:
//     WIDTH  - data width of d0, d1, y and y_q (legal range 1..64)
//
//   Ports (positional order s, d0, d1, y is relied on by existing
//   datapath instantiations; the clocked ports are appended after y):
//     s      in   1      select; 0 picks d0, 1 picks d1
//     d0     in   WIDTH  data selected when s=0
//     d1     in   WIDTH  data selected when s=1
//     y      out  WIDTH  combinational mux result, never reset
//     clk    in   1      rising-edge clock for the output register
//     reset  in   1      asynchronous active-high clear of y_q only
//     en     in   1      load enable for the output register
//     y_q    out  WIDTH  registered copy of y, one cycle behind
//
//   Build options:
//     MUX2_TRACE_EN - when defined, a simulation-only trace prints a line
//                     whenever s, d0, d1 or y changes. Not compiled by
//                     synthesis and does not alter y or y_q.
module mux2_sel
    import mux2_sel_pkg::*;
#(
    parameter int unsigned WIDTH = MUX2_DEFAULT_WIDTH
) (
    input  logic             s,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] y,
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] y_q
);

    // The ?: form is kept deliberately: with an unknown select, simulation
    // yields d0 on bits where both inputs agree and X elsewhere, which is
    // the behaviour the surrounding datapath models expect.
    assign y = s ? d1 : d0;

    // Registered copy of the mux result. Reset is asynchronous and takes
    // priority over a simultaneous enable; with en low the value holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q <= '0;
        end else if (en) begin
            y_q <= y;
        end
    end

`ifdef MUX2_TRACE_EN
`ifndef SYNTHESIS
    // Change trace for debugging selection trees in simulation.
    always @(s or d0 or d1 or y) begin
        $display("[mux2_sel] t=%0t s=%b d0=%0d d1=%0d y=%0d", $time, s, d0, d1, y);
    end
`endif
`endif

endmodule : mux2_sel

// File: tb/tb_mux2_sel.sv
// tb_mux2_sel
//   Directed bench for mux2_sel: 32-bit instance (combinational path,
//   register load/hold, asynchronous reset), 8-bit and 1-bit width
//   instances, and a 4:1 selector built from three 2:1 instances.
module tb_mux2_sel;

    // Main 32-bit instance
    logic        clk;
    logic        reset;
    logic        s;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        en;
    logic [31:0] y;
    logic [31:0] y_q;

    // 8-bit instance
    logic        s8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [7:0]  y8;
    logic [7:0]  y8_q;

    // 1-bit instance
    logic        s1;
    logic        a1;
    logic        b1;
    logic        y1;
    logic        y1_q;

    // 4:1 tree
    logic [1:0]  sel4;
    logic [31:0] t0, t1, t2, t3;
    logic [31:0] stage_a, stage_b, y4;
    logic [31:0] qa, qb, q4;
    logic        en_idle;

    int checks;
    int failures;

    mux2_sel #(.WIDTH(32)) dut (
        .s(s), .d0(d0), .d1(d1), .y(y),
        .clk(clk), .reset(reset), .en(en), .y_q(y_q)
    );

    mux2_sel #(.WIDTH(8)) dut8 (
        .s(s8), .d0(a8), .d1(b8), .y(y8),
        .clk(clk), .reset(reset), .en(en_idle), .y_q(y8_q)
    );

    mux2_sel #(.WIDTH(1)) dut1 (
        .s(s1), .d0(a1), .d1(b1), .y(y1),
        .clk(clk), .reset(reset), .en(en_idle), .y_q(y1_q)
    );

    mux2_sel #(.WIDTH(32)) tree_lo (
        .s(sel4[1]), .d0(t0), .d1(t2), .y(stage_a),
        .clk(clk), .reset(reset), .en(en_idle), .y_q(qa)
    );

    mux2_sel #(.WIDTH(32)) tree_hi (
        .s(sel4[1]), .d0(t1), .d1(t3), .y(stage_b),
        .clk(clk), .reset(reset), .en(en_idle), .y_q(qb)
    );

    mux2_sel #(.WIDTH(32)) tree_out (
        .s(sel4[0]), .d0(stage_a), .d1(stage_b), .y(y4),
        .clk(clk), .reset(reset), .en(en_idle), .y_q(q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic sv, input logic [31:0] v0,
                                 input logic [31:0] v1, input logic ev);
        s  = sv;
        d0 = v0;
        d1 = v1;
        en = ev;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [7:0]  truth1;
    logic [31:0] held;
    logic [31:0] tree_exp [4];

    initial begin
        checks   = 0;
        failures = 0;
        en_idle  = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0;
        s1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        sel4 = 2'b00; t0 = 32'd10; t1 = 32'd20; t2 = 32'd30; t3 = 32'd40;

        // Reset state: y_q cleared, y still combinational
        reset = 1'b1;
        applyStimulus(1'b1, 32'h0000_0011, 32'h0000_0022, 1'b0);
        checkOutput("reset_yq", y_q, 64'h0);
        checkOutput("reset_y_follows", y, 64'h22);

        @(negedge clk);
        reset = 1'b0;

        // Select 0, load on one enabled edge
        applyStimulus(1'b0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        checkOutput("sel0_y", y, 64'h5);
        checkOutput("sel0_yq_before_edge", y_q, 64'h0);
        @(posedge clk); #1;
        en = 1'b0;
        checkOutput("sel0_yq_loaded", y_q, 64'h5);

        // Select 1, then flip select with no clock
        applyStimulus(1'b1, 32'h0000_0007, 32'h8000_0000, 1'b0);
        checkOutput("sel1_y", y, 64'h8000_0000);
        applyStimulus(1'b0, 32'h0000_0007, 32'h8000_0000, 1'b0);
        checkOutput("toggle_y", y, 64'h7);
        checkOutput("toggle_yq_unchanged", y_q, 64'h5);

        // Async reset between edges
        @(negedge clk);
        applyStimulus(1'b0, 32'h1234_5678, 32'h0, 1'b1);
        @(posedge clk); #1;
        checkOutput("load_1234", y_q, 64'h1234_5678);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_yq", y_q, 64'h0);
        applyStimulus(1'b1, 32'h1234_5678, 32'hCAFE_0001, 1'b1);
        checkOutput("reset_y_tracks", y, 64'hCAFE_0001);
        @(posedge clk); #1;
        checkOutput("reset_beats_en", y_q, 64'h0);
        reset = 1'b0;
        #2;
        checkOutput("release_midcycle_yq", y_q, 64'h0);
        @(posedge clk); #1;
        checkOutput("post_reset_load", y_q, 64'hCAFE_0001);

        // Hold with en=0 across three edges while inputs change
        held = 32'hCAFE_0001;
        applyStimulus(1'b0, 32'h0000_00A1, 32'h0000_00B1, 1'b0);
        checkOutput("hold_y_0", y, 64'hA1);
        @(posedge clk); #1;
        checkOutput("hold_yq_0", y_q, {32'h0, held});
        applyStimulus(1'b1, 32'h0000_00A2, 32'h0000_00B2, 1'b0);
        checkOutput("hold_y_1", y, 64'hB2);
        @(posedge clk); #1;
        checkOutput("hold_yq_1", y_q, {32'h0, held});
        applyStimulus(1'b0, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
        checkOutput("hold_y_2", y, 64'hFFFF_0000);
        @(posedge clk); #1;
        checkOutput("hold_yq_2", y_q, {32'h0, held});

        // Load again after the hold to see the 1-cycle latency path
        applyStimulus(1'b1, 32'h0000_0000, 32'h5555_AAAA, 1'b1);
        @(posedge clk); #1;
        en = 1'b0;
        checkOutput("reload_yq", y_q, 64'h5555_AAAA);

        // WIDTH=8 instance
        s8 = 1'b1; a8 = 8'h5A; b8 = 8'hA5; #1;
        checkOutput("w8_sel1", {56'h0, y8}, 64'hA5);
        s8 = 1'b0; #1;
        checkOutput("w8_sel0", {56'h0, y8}, 64'h5A);

        // WIDTH=1 instance, truth table indexed by {s,d0,d1}
        truth1 = 8'b1010_1100;
        for (int i = 0; i < 8; i++) begin
            s1 = i[2];
            a1 = i[1];
            b1 = i[0];
            #1;
            checkOutput($sformatf("w1_idx%0d", i), {63'h0, y1}, {63'h0, truth1[i]});
        end

        // 4:1 tree
        tree_exp[0] = 32'd10;
        tree_exp[1] = 32'd20;
        tree_exp[2] = 32'd30;
        tree_exp[3] = 32'd40;
        for (int i = 0; i < 4; i++) begin
            sel4 = i[1:0];
            #1;
            checkOutput($sformatf("tree_sel%0d", i), {32'h0, y4}, {32'h0, tree_exp[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux2_sel
